// File: rtl/rx_frame_controller.sv
// UART receive-side controller: applies config while the line is idle,
// captures completed frames after a settle delay and queues them for the host.
module rx_frame_controller #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDLE_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             DataTx,
  input  logic             RxFlag,
  input  logic [7:0]       RxData,
  input  logic [2:0]       RxErrorFlag,
  output logic             RxResetN,
  output logic [1:0]       RxBaudRate,
  output logic [1:0]       RxParityType,
  input  logic             CfgWrite,
  input  logic [1:0]       CfgBaud,
  input  logic [1:0]       CfgParity,
  output logic             CfgBusy,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [7:0]       OutData,
  output logic [2:0]       OutError,
  output logic             Overflow,
  output logic [CNT_W-1:0] ErrCount,
  input  logic             ClrStatus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_RECONFIG
  } state_t;

  state_t state, state_next;

  logic [IW-1:0] idle_cnt;
  logic          line_idle;
  logic          rx_prev;
  logic          flag_rise;
  logic [SW-1:0] settle_cnt;
  logic          settle_done;
  logic          capture;
  logic          in_reconf;
  logic [1:0]    pend_baud;
  logic [1:0]    pend_par;

  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  assign line_idle   = (idle_cnt == IW'(IDLE_CYCLES));
  assign flag_rise   = RxFlag & ~rx_prev;
  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign OutValid    = (count != '0);
  assign pop         = OutValid & OutReady;
  assign push        = capture & (~full | pop);
  assign OutData     = OutValid ? mem[rd_ptr][7:0] : 8'h00;
  assign OutError    = OutValid ? mem[rd_ptr][10:8] : 3'b000;

  // Count consecutive high line cycles, saturating at the idle threshold
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      idle_cnt <= '0;
    end else if (!DataTx) begin
      idle_cnt <= '0;
    end else if (!line_idle) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // RxFlag history for rise detection
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) rx_prev <= 1'b0;
    else         rx_prev <= RxFlag;
  end

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a frame edge takes priority over a pending reconfig
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (flag_rise)              state_next = S_SETTLE;
        else if (CfgBusy && line_idle) state_next = S_RECONFIG;
      end
      S_SETTLE:   if (settle_done) state_next = S_CAPTURE;
      S_CAPTURE:  state_next = S_IDLE;
      S_RECONFIG: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    capture   = 1'b0;
    in_reconf = 1'b0;
    unique case (state)
      S_CAPTURE:  capture   = 1'b1;
      S_RECONFIG: in_reconf = 1'b1;
      default: ;
    endcase
  end

  // Settle delay counter, only runs in SETTLE
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)                 settle_cnt <= '0;
    else if (state == S_SETTLE)  settle_cnt <= settle_cnt + SW'(1);
    else                         settle_cnt <= '0;
  end

  // Receiver reset and settings, updated as RECONFIG is entered
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      RxResetN     <= 1'b0;
      RxBaudRate   <= 2'b00;
      RxParityType <= 2'b00;
    end else begin
      RxResetN <= (state_next != S_RECONFIG);
      if (state_next == S_RECONFIG) begin
        RxBaudRate   <= pend_baud;
        RxParityType <= pend_par;
      end
    end
  end

  // Host config request; first request held until applied
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      CfgBusy   <= 1'b0;
      pend_baud <= 2'b00;
      pend_par  <= 2'b00;
    end else if (in_reconf) begin
      CfgBusy <= 1'b0;
    end else if (CfgWrite && !CfgBusy) begin
      CfgBusy   <= 1'b1;
      pend_baud <= CfgBaud;
      pend_par  <= CfgParity;
    end
  end

  // Frame FIFO storage and pointers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {RxErrorFlag, RxData};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Sticky status; clear beats a same-cycle update
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Overflow <= 1'b0;
      ErrCount <= '0;
    end else if (ClrStatus) begin
      Overflow <= 1'b0;
      ErrCount <= '0;
    end else begin
      if (capture && full && !pop) Overflow <= 1'b1;
      if (capture && (RxErrorFlag != 3'b000) && (ErrCount != '1))
        ErrCount <= ErrCount + CNT_W'(1);
    end
  end

endmodule
